// File: rtl/parking_slot_selector_if.sv
// rtl/parking_slot_selector_if.sv - user-input and selection bus of the parking slot selector
//
// Purpose: groups the button/keypad/occupancy inputs and the registered
//          selection outputs of parking_slot_selector into one bundle.
// Signals:
//   bt_out        debounced buttons (bit1 left, bit0 right, bit3 mid/confirm)
//   view          current UI view code
//   key_out       one-hot keypad level, bit i requests slot i+1
//   occupied      bit i high = slot i+1 taken
//   confirm_ack   consumer accepts the held selection
//   slot          selected slot 1..N_SLOTS, 0 when all slots are full
//   confirm_valid selection offered to the consumer
//   all_full      every slot is taken
//   fsm_state     0 BROWSE, 1 HOLD, 2 FULL
// Modports: master drives the inputs and observes the outputs,
//           slave is the selector itself.
interface parking_slot_selector_if #(
   parameter int N_SLOTS = 8
);
   logic [4:0]         bt_out;
   logic [2:0]         view;
   logic [15:0]        key_out;
   logic [N_SLOTS-1:0] occupied;
   logic               confirm_ack;
   logic [3:0]         slot;
   logic               confirm_valid;
   logic               all_full;
   logic [1:0]         fsm_state;

   modport master (
      output bt_out, view, key_out, occupied, confirm_ack,
      input  slot, confirm_valid, all_full, fsm_state
   );

   modport slave (
      input  bt_out, view, key_out, occupied, confirm_ack,
      output slot, confirm_valid, all_full, fsm_state
   );
endinterface

// File: rtl/parking_slot_selector.sv
// rtl/parking_slot_selector.sv - parking slot browse/confirm selector
//
// Purpose: lets the user step through free parking slots with left/right
//          buttons or pick one directly from the keypad, then offers the
//          chosen slot to a consumer with a valid/ack handshake. Follows the
//          occupancy map on its own: an occupied selection moves to the next
//          free slot, and a completely full car park parks the selector in
//          FULL until a slot frees.
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   sel_if  parking_slot_selector_if.slave (buttons, view, keypad,
//           occupancy, confirm_ack in; slot, confirm_valid, all_full,
//           fsm_state out, all registered)
module parking_slot_selector #(
   parameter int         N_SLOTS  = 8,
   parameter logic [2:0] VIEW_SEL = 3'd0
) (
   input  logic                   clk,
   input  logic                   rst,
   parking_slot_selector_if.slave sel_if
);

   typedef enum logic [1:0] {
      ST_BROWSE = 2'd0,
      ST_HOLD   = 2'd1,
      ST_FULL   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         slot_q, slot_d;
   logic               cv_q, cv_d;
   logic               full_q, full_d;
   logic               lockout_q;
   logic [N_SLOTS-1:0] key_prev_q;

   logic [N_SLOTS-1:0] occ;
   logic [N_SLOTS-1:0] keys;
   logic               view_ok;
   logic               btn_any;
   logic               press;
   logic               key_rise;
   logic               ev_mid, ev_key, ev_right, ev_left;
   logic               all_occ;

   logic [3:0]         up_slot, dn_slot, low_slot, key_slot;
   logic               up_found, dn_found, low_found, key_found;
   logic               key_free;
   int                 cur, idx_up, idx_dn;

   logic               unused_bits;

   assign occ      = sel_if.occupied;
   assign keys     = sel_if.key_out[N_SLOTS-1:0];
   assign view_ok  = (sel_if.view == VIEW_SEL);
   assign btn_any  = sel_if.bt_out[3] | sel_if.bt_out[1] | sel_if.bt_out[0];
   assign all_occ  = &occ;

   // A press counts only on the first cycle any button is high, so holding a
   // button never repeats the action.
   assign press    = view_ok && !lockout_q && btn_any;
   assign key_rise = view_ok && (key_prev_q == '0) && (keys != '0);

   // Only the highest-priority recognised event acts: mid > keypad > right > left.
   assign ev_mid   = press && sel_if.bt_out[3];
   assign ev_key   = !ev_mid && key_rise;
   assign ev_right = !ev_mid && !ev_key && press && sel_if.bt_out[0];
   assign ev_left  = !ev_mid && !ev_key && !ev_right && press && sel_if.bt_out[1];

   assign unused_bits = ^{sel_if.bt_out[4], sel_if.bt_out[2], sel_if.key_out[15:N_SLOTS]};

   // Single-cycle wrap search over the other N_SLOTS-1 slots in both
   // directions, plus lowest free slot and lowest requested key.
   always_comb begin
      up_slot   = slot_q;
      dn_slot   = slot_q;
      low_slot  = 4'd1;
      key_slot  = 4'd1;
      up_found  = 1'b0;
      dn_found  = 1'b0;
      low_found = 1'b0;
      key_found = 1'b0;
      idx_up    = 0;
      idx_dn    = 0;
      cur       = (slot_q == 4'd0) ? 0 : int'(slot_q) - 1;
      for (int k = 1; k < N_SLOTS; k++) begin
         idx_up = (cur + k) % N_SLOTS;
         idx_dn = (cur - k + N_SLOTS) % N_SLOTS;
         if (!up_found && !occ[idx_up]) begin
            up_found = 1'b1;
            up_slot  = 4'(idx_up + 1);
         end
         if (!dn_found && !occ[idx_dn]) begin
            dn_found = 1'b1;
            dn_slot  = 4'(idx_dn + 1);
         end
      end
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!low_found && !occ[i]) begin
            low_found = 1'b1;
            low_slot  = 4'(i + 1);
         end
         if (!key_found && keys[i]) begin
            key_found = 1'b1;
            key_slot  = 4'(i + 1);
         end
      end
   end

   assign key_free = key_found && !occ[key_slot - 4'd1];

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      cv_d    = cv_q;
      full_d  = full_q;
      case (state_q)
         ST_BROWSE: begin
            if (all_occ) begin
               state_d = ST_FULL;
               slot_d  = 4'd0;
               full_d  = 1'b1;
            end else if (occ[slot_q - 4'd1]) begin
               // Selection was taken under us: relocate upward, user events
               // in the same cycle are dropped.
               slot_d = up_slot;
            end else if (ev_mid) begin
               state_d = ST_HOLD;
               cv_d    = 1'b1;
            end else if (ev_key) begin
               if (key_free) begin
                  slot_d = key_slot;
               end
            end else if (ev_right) begin
               slot_d = up_slot;
            end else if (ev_left) begin
               slot_d = dn_slot;
            end
         end
         ST_HOLD: begin
            if (sel_if.confirm_ack) begin
               state_d = ST_BROWSE;
               cv_d    = 1'b0;
            end
         end
         ST_FULL: begin
            if (!all_occ) begin
               state_d = ST_BROWSE;
               slot_d  = low_slot;
               full_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_BROWSE;
            slot_d  = 4'd1;
            cv_d    = 1'b0;
            full_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BROWSE;
         slot_q     <= 4'd1;
         cv_q       <= 1'b0;
         full_q     <= 1'b0;
         // Buttons or keys held through reset must not count as new events.
         lockout_q  <= 1'b1;
         key_prev_q <= '1;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         cv_q       <= cv_d;
         full_q     <= full_d;
         lockout_q  <= btn_any;
         key_prev_q <= keys;
      end
   end

   assign sel_if.slot          = slot_q;
   assign sel_if.confirm_valid = cv_q;
   assign sel_if.all_full      = full_q;
   assign sel_if.fsm_state     = state_q;

endmodule

// File: tb/tb_parking_slot_selector.sv
// tb/tb_parking_slot_selector.sv - scoreboard bench for parking_slot_selector
module tb_parking_slot_selector;

   localparam int         N        = 8;
   localparam logic [2:0] VIEW_SEL = 3'd0;

   typedef struct {
      int slot;
      int cv;
      int full;
      int st;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   parking_slot_selector_if #(.N_SLOTS(N)) bus ();

   parking_slot_selector #(.N_SLOTS(N), .VIEW_SEL(VIEW_SEL)) dut (
      .clk    (clk),
      .rst    (rst),
      .sel_if (bus)
   );

   always #5 clk = ~clk;

   // Stimulus state
   logic       cur_rst  = 1'b1;
   logic [4:0] cur_bt   = '0;
   logic [2:0] cur_view = VIEW_SEL;
   logic [15:0] cur_key = '0;
   logic [7:0] cur_occ  = '0;
   logic       cur_ack  = 1'b0;

   // Reference model state
   int       m_slot, m_state, m_cv, m_full;
   bit       m_prev_btn;
   bit [7:0] m_prev_key;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   done  = 0;

   initial begin
      bus.bt_out      = '0;
      bus.view        = VIEW_SEL;
      bus.key_out     = '0;
      bus.occupied    = '0;
      bus.confirm_ack = 1'b0;
   end

   function automatic int next_free(int s, int dir, bit [7:0] occ);
      for (int k = 1; k < N; k++) begin
         int c;
         c = (((s - 1) + dir * k) % N + N) % N;
         if (!occ[c]) return c + 1;
      end
      return s;
   endfunction

   function automatic int lowest_set(bit [7:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_step();
      bit       btn_any, ok, press, krise;
      bit [7:0] k8;
      int       ev;
      k8 = cur_key[7:0];
      if (cur_rst) begin
         m_slot = 1; m_state = 0; m_cv = 0; m_full = 0;
         m_prev_btn = 1; m_prev_key = 8'hFF;
         return;
      end
      btn_any = cur_bt[3] | cur_bt[1] | cur_bt[0];
      ok      = (cur_view == VIEW_SEL);
      press   = ok && !m_prev_btn && btn_any;
      krise   = ok && (m_prev_key == 0) && (k8 != 0);
      ev = 0;
      if (press && cur_bt[3])      ev = 4;
      else if (krise)              ev = 3;
      else if (press && cur_bt[0]) ev = 2;
      else if (press && cur_bt[1]) ev = 1;
      case (m_state)
         0: begin
            if (cur_occ == 8'hFF) begin
               m_state = 2; m_slot = 0; m_full = 1;
            end else if (cur_occ[m_slot-1]) begin
               m_slot = next_free(m_slot, 1, cur_occ);
            end else if (ev == 4) begin
               m_state = 1; m_cv = 1;
            end else if (ev == 3) begin
               int req;
               req = lowest_set(k8);
               if (!cur_occ[req-1]) m_slot = req;
            end else if (ev == 2) begin
               m_slot = next_free(m_slot, 1, cur_occ);
            end else if (ev == 1) begin
               m_slot = next_free(m_slot, -1, cur_occ);
            end
         end
         1: if (cur_ack) begin m_state = 0; m_cv = 0; end
         default: if (cur_occ != 8'hFF) begin
            m_state = 0; m_full = 0; m_slot = lowest_set(~cur_occ);
         end
      endcase
      m_prev_btn = btn_any;
      m_prev_key = k8;
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      rst             = cur_rst;
      bus.bt_out      = cur_bt;
      bus.view        = cur_view;
      bus.key_out     = cur_key;
      bus.occupied    = cur_occ;
      bus.confirm_ack = cur_ack;
      model_step();
      e.slot = m_slot; e.cv = m_cv; e.full = m_full; e.st = m_state;
      exp_q.push_back(e);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_bt(logic [4:0] b);
      cur_bt = b; tick();
      cur_bt = '0; tick();
   endtask

   task automatic pulse_key(logic [15:0] k);
      cur_key = k; tick();
      cur_key = '0; tick();
   endtask

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are registered and always presented, so one expected
   // entry is consumed after every active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slot",          int'(bus.slot),          e.slot);
            check("confirm_valid", int'(bus.confirm_valid), e.cv);
            check("all_full",      int'(bus.all_full),      e.full);
            check("fsm_state",     int'(bus.fsm_state),     e.st);
         end
      end
   end

   initial begin
      // Reset
      cur_rst = 1; ticks(2);
      cur_rst = 0; ticks(2);

      // Wrap left 1 -> 8, right 8 -> 1, left 1 -> 8
      pulse_bt(5'b00010);
      pulse_bt(5'b00001);
      pulse_bt(5'b00010);
      pulse_bt(5'b00001);

      // Skip occupied slots 2,3; held right moves once
      cur_occ = 8'b0000_0110; tick();
      pulse_bt(5'b00001);
      cur_bt = 5'b00001; ticks(20);
      cur_bt = '0; tick();

      // Keypad: occupied request ignored, free request taken
      cur_occ = 8'b0010_0000; tick();
      pulse_key(16'h0020);
      pulse_key(16'h0010);
      // Ignored bits above N_SLOTS
      pulse_key(16'h0100);
      pulse_key(16'h0004);

      // Confirm slot 3, inputs ignored while held
      pulse_bt(5'b01000);
      for (int i = 0; i < 5; i++) begin
         pulse_bt(5'b00010);
         pulse_key(16'h0001);
      end
      cur_occ = 8'b0010_0100; ticks(2);
      cur_ack = 1; tick();
      cur_ack = 0; ticks(3);

      // All full, then slot 6 frees
      cur_occ = 8'hFF; ticks(3);
      pulse_bt(5'b01000);
      cur_occ = 8'hDF; ticks(3);

      // Reset in HOLD with mid held
      cur_occ = 8'h00; tick();
      pulse_bt(5'b01000);
      cur_bt  = 5'b01000; ticks(2);
      cur_rst = 1; ticks(2);
      cur_rst = 0; ticks(3);
      cur_bt  = '0; ticks(2);

      // Ack outside HOLD ignored
      cur_ack = 1; ticks(2);
      cur_ack = 0; tick();

      // View gating: events ignored, auto-relocation still acts
      cur_view = 3'd4;
      pulse_bt(5'b00001);
      pulse_key(16'h0008);
      cur_occ = 8'h01; ticks(2);
      cur_view = VIEW_SEL; cur_occ = 8'h00; tick();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cur_rst  = ($urandom_range(0, 299) == 0);
         cur_view = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : VIEW_SEL;
         cur_bt   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         if ($urandom_range(0, 4) == 0)
            cur_key = ($urandom_range(0, 2) == 0) ? 16'($urandom) : (16'd1 << $urandom_range(0, 15));
         else if ($urandom_range(0, 2) == 0)
            cur_key = '0;
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0:       cur_occ = 8'hFF;
               1:       cur_occ = 8'hFF ^ (8'd1 << $urandom_range(0, 7));
               default: cur_occ = 8'($urandom);
            endcase
         end
         cur_ack = ($urandom_range(0, 3) == 0);
         tick();
      end

      cur_rst = 0; cur_bt = '0; cur_key = '0; cur_ack = 0;
      ticks(2);
      @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish, got 1 expected 0");
      $fatal(1);
   end

endmodule
